sc_game_sequencer: RTL

SC_GAME_SEQUENCER -- requirements
Module: sc_game_sequencer

---
 rtl/sc_game_pkg.sv | 19 +
 rtl/sc_pause_timer.sv | 36 +++
 rtl/sc_game_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sc_game_pkg.sv
// Shared types and defaults for the game sequencer slice.
package sc_game_pkg;

    localparam int unsigned LIVES_W        = 2;
    localparam int unsigned LEVEL_W        = 3;
    localparam int unsigned LIVES_INIT_DEF = 3;
    localparam int unsigned LEVELS_MAX_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLAY,
        S_HIT,
        S_LEVELUP,
        S_WIN,
        S_GAMEOVER
    } state_t;

endpackage

// File: rtl/sc_pause_timer.sv
// Post-hit freeze timer: a start pulse arms it, and done is high during the
// last of PAUSE_CYCLES busy cycles.
module sc_pause_timer #(
    parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    logic [CW-1:0] count;
    logic          busy;

    assign done = busy && (count == '0);

    // Load on start, then count down to zero while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            count <= CW'(PAUSE_CYCLES - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sc_game_sequencer.sv
// Game flow controller: start, play, hit pause, level-up, win and game-over.
module sc_game_sequencer
    import sc_game_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
    parameter int unsigned LEVELS_MAX   = LEVELS_MAX_DEF,
    parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
    input  logic               SC_GAME_SEQUENCER_CLOCK_50,
    input  logic               SC_GAME_SEQUENCER_RESET_InHigh,
    input  logic               SC_GAME_SEQUENCER_startButton_InLow,
    input  logic               SC_GAME_SEQUENCER_Losing_InLow,
    input  logic               SC_GAME_SEQUENCER_Goal_InLow,
    output logic               SC_GAME_SEQUENCER_clear_OutLow,
    output logic               SC_GAME_SEQUENCER_respawn_OutLow,
    output logic [LIVES_W-1:0] SC_GAME_SEQUENCER_lives_Out,
    output logic [LEVEL_W-1:0] SC_GAME_SEQUENCER_level_Out,
    output logic               SC_GAME_SEQUENCER_playing_OutHigh,
    output logic               SC_GAME_SEQUENCER_win_OutHigh,
    output logic               SC_GAME_SEQUENCER_gameover_OutHigh
);

    logic clk;
    logic rst;
    assign clk = SC_GAME_SEQUENCER_CLOCK_50;
    assign rst = SC_GAME_SEQUENCER_RESET_InHigh;

    state_t             state;
    state_t             next_state;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic               sync_1;
    logic               sync_2;
    logic               sync_3;
    logic               start_evt;
    logic               pause_start;
    logic               pause_done;
    logic               clear_n;
    logic               respawn_n;
    logic               playing;
    logic               win;
    logic               gameover;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
        end else begin
            sync_1 <= SC_GAME_SEQUENCER_startButton_InLow;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign start_evt = sync_3 && !sync_2;

    sc_pause_timer #(
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_pause (
        .clk  (clk),
        .rst  (rst),
        .start(pause_start),
        .done (pause_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Lives and level bookkeeping, keyed off the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives <= '0;
            level <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    lives <= LIVES_W'(LIVES_INIT);
                    level <= LEVEL_W'(1);
                end
                S_PLAY: begin
                    if (!SC_GAME_SEQUENCER_Losing_InLow && (lives != '0)) begin
                        lives <= lives - LIVES_W'(1);
                    end
                end
                S_LEVELUP: begin
                    if (level < LEVEL_W'(LEVELS_MAX)) begin
                        level <= level + LEVEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state, strobes and status flags; collision takes priority over goal.
    always_comb begin
        next_state  = state;
        clear_n     = 1'b1;
        respawn_n   = 1'b1;
        pause_start = 1'b0;
        playing     = 1'b0;
        win         = 1'b0;
        gameover    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_evt) next_state = S_CLEAR;
            end
            S_CLEAR: begin
                clear_n    = 1'b0;
                next_state = S_PLAY;
            end
            S_PLAY: begin
                playing = 1'b1;
                if (!SC_GAME_SEQUENCER_Losing_InLow) begin
                    next_state  = S_HIT;
                    pause_start = 1'b1;
                end else if (!SC_GAME_SEQUENCER_Goal_InLow) begin
                    next_state = (level == LEVEL_W'(LEVELS_MAX)) ? S_WIN : S_LEVELUP;
                end
            end
            S_HIT: begin
                playing = 1'b1;
                if (pause_done) begin
                    if (lives == '0) begin
                        next_state = S_GAMEOVER;
                    end else begin
                        next_state = S_PLAY;
                        respawn_n  = 1'b0;
                    end
                end
            end
            S_LEVELUP: begin
                playing    = 1'b1;
                respawn_n  = 1'b0;
                next_state = S_PLAY;
            end
            S_WIN: begin
                win = 1'b1;
                if (start_evt) next_state = S_CLEAR;
            end
            S_GAMEOVER: begin
                gameover = 1'b1;
                if (start_evt) next_state = S_CLEAR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign SC_GAME_SEQUENCER_clear_OutLow      = clear_n;
    assign SC_GAME_SEQUENCER_respawn_OutLow    = respawn_n;
    assign SC_GAME_SEQUENCER_lives_Out         = lives;
    assign SC_GAME_SEQUENCER_level_Out         = level;
    assign SC_GAME_SEQUENCER_playing_OutHigh   = playing;
    assign SC_GAME_SEQUENCER_win_OutHigh       = win;
    assign SC_GAME_SEQUENCER_gameover_OutHigh  = gameover;

endmodule
